// File: rtl/pipe_pkg.sv
// Shared definitions for the micropipeline injection arbiter and stages.
// State encodings, default data width and round-robin selection.
package pipe_pkg;

    localparam int W_DEF = 3;

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] SETUP       = 2'd1;
    localparam logic [1:0] WAIT_ACK_HI = 2'd2;
    localparam logic [1:0] WAIT_ACK_LO = 2'd3;

    // First set bit of valid scanning upward from last+1, modulo n (n <= 8).
    function automatic logic [2:0] next_rr(
        input logic [7:0] valid,
        input logic [2:0] last,
        input int         n
    );
        logic [2:0] sel;
        bit         found;
        int         idx;
        sel   = last;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!found && k <= n) begin
                idx = (int'(last) + k) % n;
                if (valid[idx[2:0]]) begin
                    sel   = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level.
// Synchronous active-high reset clears every stage.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r;

    always_ff @(posedge clk) begin
        if (rst) r <= '0;
        else     r <= {r[STAGES-2:0], d};
    end

    assign q = r[STAGES-1];

endmodule

// File: rtl/pipe_inject_arbiter.sv
// Round-robin injector of clocked requester words into the head of an
// asynchronous micropipeline using a 4-phase bundled-data handshake.
module pipe_inject_arbiter
    import pipe_pkg::*;
#(
    parameter int N           = 2,
    parameter int W           = W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         src_valid,
    input  logic [N*W-1:0]       src_data,
    output logic [N-1:0]         src_ready,
    output logic                 req_out,
    output logic [W-1:0]         data_out,
    input  logic                 ack_in,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     tokens_sent
);

    localparam int GW = $clog2(N);

    logic [1:0] state;
    logic       ack_s;
    logic [2:0] nxt;

    sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_in),
        .q   (ack_s)
    );

    assign nxt  = next_rr(8'(src_valid), 3'(grant_id), N);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_out     <= 1'b0;
            data_out    <= '0;
            src_ready   <= '0;
            grant_id    <= GW'(N - 1);
            tokens_sent <= '0;
        end else begin
            src_ready <= '0;
            case (state)
                IDLE: begin
                    // A stale ack from the previous token blocks new grants.
                    if (|src_valid && !ack_s) begin
                        data_out            <= src_data[int'(nxt)*W +: W];
                        grant_id            <= nxt[GW-1:0];
                        src_ready[nxt[GW-1:0]] <= 1'b1;
                        state               <= SETUP;
                    end
                end
                SETUP: begin
                    req_out <= 1'b1;
                    state   <= WAIT_ACK_HI;
                end
                WAIT_ACK_HI: begin
                    if (ack_s) begin
                        req_out <= 1'b0;
                        state   <= WAIT_ACK_LO;
                    end
                end
                default: begin
                    if (!ack_s) begin
                        tokens_sent <= tokens_sent + 1'b1;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_inject_arbiter.sv
// Directed bench for pipe_inject_arbiter with a delayed-echo pipeline
// stage model driving ack_in.
module tb_pipe_inject_arbiter;

    localparam int N  = 2;
    localparam int W  = 3;
    localparam int SS = 2;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   src_valid = '0;
    logic [N*W-1:0] src_data = '0;
    logic [N-1:0]   src_ready;
    logic           req_out;
    logic [W-1:0]   data_out;
    logic           ack_in;
    logic [0:0]     grant_id;
    logic           busy;
    logic [CW-1:0]  tokens_sent;

    logic [3:0] dly = 4'd0;
    logic       ack_force = 1'b0;
    logic       ack_val = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_inject_arbiter #(
        .N(N), .W(W), .SYNC_STAGES(SS), .CNT_W(CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .req_out     (req_out),
        .data_out    (data_out),
        .ack_in      (ack_in),
        .grant_id    (grant_id),
        .busy        (busy),
        .tokens_sent (tokens_sent)
    );

    always #5 clk = ~clk;

    // First stage model: ack echoes req_out four cycles later.
    always @(posedge clk) dly <= rst ? 4'd0 : {dly[2:0], req_out};
    assign ack_in = ack_force ? ack_val : dly[3];

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (src_ready != '0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ack_force = 1'b0;
        src_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (req_out !== 1'b0 || data_out !== 3'b000 || src_ready !== 2'b00
            || busy !== 1'b0 || grant_id !== 1'b1 || tokens_sent !== 4'd0) begin
            n_bad++;
            $display("FAIL reset: req=%b data=%b rdy=%b busy=%b gid=%b tok=%0d, want 0 000 00 0 1 0",
                     req_out, data_out, src_ready, busy, grant_id, tokens_sent);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        @(negedge clk);
        src_data  = {3'b000, 3'b101};
        src_valid = 2'b01;
        wait_grant(ok);
        n_cmp++;
        if (!ok || src_ready !== 2'b01 || data_out !== 3'b101
            || req_out !== 1'b0 || grant_id !== 1'b0) begin
            n_bad++;
            $display("FAIL single_grant: ok=%0d rdy=%b data=%b req=%b gid=%b, want 1 01 101 0 0",
                     ok, src_ready, data_out, req_out, grant_id);
        end
        src_valid = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (req_out !== 1'b1 || src_ready !== 2'b00 || data_out !== 3'b101) begin
            n_bad++;
            $display("FAIL single_req_rise: req=%b rdy=%b data=%b, want 1 00 101",
                     req_out, src_ready, data_out);
        end
        wait_idle(ok);
        n_cmp++;
        if (!ok || tokens_sent !== 4'd1 || req_out !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: ok=%0d tok=%0d req=%b, want 1 1 0",
                     ok, tokens_sent, req_out);
        end
    endtask

    task automatic test_alternate();
        bit         ok;
        logic [1:0] exp_rdy;
        logic [2:0] exp_dat;
        do_reset();
        src_data  = {3'b110, 3'b001};
        src_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_rdy = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_dat = (t % 2 == 0) ? 3'b001 : 3'b110;
            wait_grant(ok);
            n_cmp++;
            if (!ok || src_ready !== exp_rdy || data_out !== exp_dat
                || grant_id !== exp_rdy[1]) begin
                n_bad++;
                $display("FAIL alt_grant%0d: ok=%0d rdy=%b data=%b gid=%b, want 1 %b %b %b",
                         t, ok, src_ready, data_out, grant_id, exp_rdy, exp_dat, exp_rdy[1]);
            end
        end
        wait_idle(ok);
        src_valid = 2'b00;
        n_cmp++;
        if (!ok || tokens_sent !== 4'd4) begin
            n_bad++;
            $display("FAIL alt_count: ok=%0d tok=%0d, want 1 4", ok, tokens_sent);
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit held;
        ack_force = 1'b1;
        ack_val   = 1'b0;
        src_data  = {3'b000, 3'b011};
        src_valid = 2'b01;
        wait_grant(ok);
        n_cmp++;
        if (!ok || src_ready !== 2'b01 || data_out !== 3'b011) begin
            n_bad++;
            $display("FAIL stall_grant: ok=%0d rdy=%b data=%b, want 1 01 011",
                     ok, src_ready, data_out);
        end
        src_valid = 2'b00;
        src_data  = {3'b000, 3'b100};
        @(negedge clk);
        held = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (req_out !== 1'b1 || data_out !== 3'b011
                || src_ready !== 2'b00 || busy !== 1'b1)
                held = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (!held || req_out !== 1'b1 || data_out !== 3'b011 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_hold: held=%0d req=%b data=%b busy=%b, want 1 1 011 1",
                     held, req_out, data_out, busy);
        end
        ack_force = 1'b0;
        wait_idle(ok);
        n_cmp++;
        if (!ok || tokens_sent !== 4'd5 || req_out !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_release: ok=%0d tok=%0d req=%b, want 1 5 0",
                     ok, tokens_sent, req_out);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ack_force = 1'b1;
        ack_val   = 1'b0;
        src_data  = {3'b000, 3'b111};
        src_valid = 2'b01;
        wait_grant(ok);
        src_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (!ok || req_out !== 1'b1 || data_out !== 3'b111) begin
            n_bad++;
            $display("FAIL midrst_pre: ok=%0d req=%b data=%b, want 1 1 111",
                     ok, req_out, data_out);
        end
        rst     = 1'b1;
        ack_val = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_out !== 1'b0 || data_out !== 3'b000 || tokens_sent !== 4'd0
            || busy !== 1'b0 || grant_id !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_state: req=%b data=%b tok=%0d busy=%b gid=%b, want 0 000 0 0 1",
                     req_out, data_out, tokens_sent, busy, grant_id);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        src_data  = {3'b000, 3'b010};
        src_valid = 2'b01;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (src_ready !== 2'b00 || busy !== 1'b0) ok = 1'b0;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL stale_ack_block: grant seen while ack_in=1 (rdy=%b busy=%b), want none",
                     src_ready, busy);
        end
        ack_val = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (src_ready !== 2'b00 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stale_sync_delay: rdy=%b busy=%b, want 00 0",
                     src_ready, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (src_ready !== 2'b01 || data_out !== 3'b010 || grant_id !== 1'b0) begin
            n_bad++;
            $display("FAIL stale_grant: rdy=%b data=%b gid=%b, want 01 010 0",
                     src_ready, data_out, grant_id);
        end
        src_valid = 2'b00;
        ack_force = 1'b0;
        wait_idle(ok);
        n_cmp++;
        if (!ok || tokens_sent !== 4'd1) begin
            n_bad++;
            $display("FAIL stale_done: ok=%0d tok=%0d, want 1 1", ok, tokens_sent);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int got;
        do_reset();
        src_data  = {3'b000, 3'b001};
        src_valid = 2'b01;
        got = 0;
        for (int t = 0; t < 17; t++) begin
            wait_grant(ok);
            if (ok) got++;
        end
        src_valid = 2'b00;
        wait_idle(ok);
        n_cmp++;
        if (!ok || got != 17 || tokens_sent !== 4'd1 || grant_id !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap: ok=%0d grants=%0d tok=%0d gid=%b, want 1 17 1 0",
                     ok, got, tokens_sent, grant_id);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
